// File: rtl/onehot_burst_decoder.sv
// Sequential 5-to-32 burst decoder: emits one registered one-hot enable per beat.
// Optional macro ONEHOT_DEC_CHK_EN rejects out-of-range counts and pulses err.
module onehot_burst_decoder #(
  parameter int N_REGS = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_code,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_REGS-1:0] Data,
  output logic [4:0]        out_code,
  output logic              out_last,
  output logic              busy
`ifdef ONEHOT_DEC_CHK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_REGS-1:0]   data_q, data_d;
  logic [4:0]          code_q, code_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                err_q, err_d;

  logic                count_bad;
  logic [CNT_W-1:0]    eff_count;
  logic                accept;
  logic                load;
  logic                reject;

  // Zero and oversize counts both mean "full sweep" unless the checker rejects them.
  assign count_bad = (in_count == '0) || (in_count > CNT_W'(N_REGS));
  assign eff_count = count_bad ? CNT_W'(N_REGS) : in_count;
  assign accept    = in_valid && (state_q == IDLE);

`ifdef ONEHOT_DEC_CHK_EN
  assign reject = accept && count_bad;
`else
  assign reject = 1'b0;
`endif
  assign load = accept && !reject;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    code_d      = code_q;
    last_d      = last_q;
    valid_d     = valid_q;
    remaining_d = remaining_q;
    err_d       = reject;
    case (state_q)
      IDLE: begin
        if (load) begin
          code_d      = in_code;
          data_d      = N_REGS'(1) << in_code;
          remaining_d = eff_count;
          last_d      = (eff_count == CNT_W'(1));
          valid_d     = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            valid_d     = 1'b0;
            data_d      = '0;
            last_d      = 1'b0;
            remaining_d = '0;
            state_d     = IDLE;
          end else begin
            code_d      = code_q + 5'd1;
            data_d      = {data_q[N_REGS-2:0], data_q[N_REGS-1]};
            remaining_d = remaining_q - CNT_W'(1);
            last_d      = (remaining_q == CNT_W'(2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      data_q      <= '0;
      code_q      <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      code_q      <= code_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign Data      = data_q;
  assign out_code  = code_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

`ifdef ONEHOT_DEC_CHK_EN
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_onehot_burst_decoder.sv
// Self-checking bench for onehot_burst_decoder: vector table, corner sequences
// and randomized bursts checked against a code-list model.
`timescale 1ns/1ps
module tb_onehot_burst_decoder;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_code = '0;
  logic [5:0]  in_count = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Data;
  logic [4:0]  out_code;
  logic        out_last;
  logic        busy;
`ifdef ONEHOT_DEC_CHK_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;

  onehot_burst_decoder dut (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Data      (Data),
    .out_code  (out_code),
    .out_last  (out_last),
    .busy      (busy)
`ifdef ONEHOT_DEC_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  code;
    logic [5:0]  count;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [4:0]  exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: condition not reached at %0t", name, $time);
  endtask

  // Number of beats a request should produce, straight from the count rules.
  function automatic int model_beats(input logic [5:0] n);
`ifdef ONEHOT_DEC_CHK_EN
    if (n == 0 || n > 32) return 0;
`endif
    if (n == 0 || n > 32) return 32;
    return int'(n);
  endfunction

  task automatic applyStimulus(input logic [4:0] code, input logic [5:0] count);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("req_ready", in_ready, 1);
    in_valid = 1'b1;
    in_code  = code;
    in_count = count;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drive_burst(input logic [4:0] code, input logic [5:0] count, input int ready_pct,
                             output int beats, output logic [31:0] first_data, output logic [4:0] last_code);
    logic [4:0] exp_q[$];
    int n, guard, bad_at_start;
    bit done;
    n = model_beats(count);
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(5'((int'(code) + i) % 32));
    beats = 0;
    first_data = '0;
    last_code = '0;
    done = 1'b0;
    guard = 0;
    applyStimulus(code, count);
    if (n == 0) begin
      checkOutput("badcnt_valid", out_valid, 0);
      checkOutput("badcnt_ready", in_ready, 1);
`ifdef ONEHOT_DEC_CHK_EN
      checkOutput("err_pulse", err, 1);
      @(negedge clock);
      checkOutput("err_clear", err, 0);
      checkOutput("badcnt_valid2", out_valid, 0);
`endif
      return;
    end
    bad_at_start = bad;
    while (!done && guard < 500 && bad == bad_at_start) begin
      checkOutput("beat_valid", out_valid, 1);
      checkOutput("beat_busy", busy, 1);
      checkOutput("beat_in_ready", in_ready, 0);
      checkOutput("beat_code", out_code, exp_q[0]);
      checkOutput("beat_data", Data, 32'd1 << exp_q[0]);
      checkOutput("beat_last", out_last, exp_q.size() == 1);
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        if (beats == 0) first_data = Data;
        last_code = out_code;
        beats++;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done = 1'b1;
      end
      @(negedge clock);
      guard++;
    end
    if (!done && bad == bad_at_start) fail_now("burst_timeout");
    checkOutput("post_valid", out_valid, 0);
    checkOutput("post_data", Data, 0);
    checkOutput("post_ready", in_ready, 1);
    checkOutput("post_busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    logic [31:0] first_data;
    logic [4:0] last_code;
    logic [4:0] rc;
    logic [5:0] rn;

    vecs[0] = '{5'd5,  6'd1,  1,  32'h0000_0020, 5'd5};
    vecs[1] = '{5'd30, 6'd4,  4,  32'h4000_0000, 5'd1};
    vecs[2] = '{5'd31, 6'd2,  2,  32'h8000_0000, 5'd0};
    vecs[3] = '{5'd12, 6'd32, 32, 32'h0000_1000, 5'd11};
`ifdef ONEHOT_DEC_CHK_EN
    vecs[4] = '{5'd0,  6'd0,  0,  32'h0,         5'd0};
    vecs[5] = '{5'd7,  6'd45, 0,  32'h0,         5'd0};
    vecs[6] = '{5'd3,  6'd33, 0,  32'h0,         5'd0};
`else
    vecs[4] = '{5'd0,  6'd0,  32, 32'h0000_0001, 5'd31};
    vecs[5] = '{5'd7,  6'd45, 32, 32'h0000_0080, 5'd6};
    vecs[6] = '{5'd3,  6'd33, 32, 32'h0000_0008, 5'd2};
`endif

    // Reset state
    repeat (2) @(negedge clock);
    clear = 1'b1;
    #1;
    checkOutput("rst_data", Data, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_last", out_last, 0);

    for (int v = 0; v < 7; v++) begin
      drive_burst(vecs[v].code, vecs[v].count, 100, beats, first_data, last_code);
      checkOutput("vec_beats", beats, vecs[v].exp_beats);
      checkOutput("vec_first", first_data, vecs[v].exp_first);
      checkOutput("vec_lastcode", last_code, vecs[v].exp_last);
    end

    // Back-pressure holds the first beat, then beats 1 and 2 follow in order
    out_ready = 1'b0;
    applyStimulus(5'd0, 6'd3);
    repeat (3) begin
      checkOutput("bp_hold_data", Data, 32'h1);
      checkOutput("bp_hold_code", out_code, 0);
      checkOutput("bp_hold_valid", out_valid, 1);
      @(negedge clock);
    end
    out_ready = 1'b1;
    checkOutput("bp_b0_data", Data, 32'h1);
    @(negedge clock);
    checkOutput("bp_b1_data", Data, 32'h2);
    checkOutput("bp_b1_code", out_code, 1);
    checkOutput("bp_b1_last", out_last, 0);
    @(negedge clock);
    checkOutput("bp_b2_data", Data, 32'h4);
    checkOutput("bp_b2_code", out_code, 2);
    checkOutput("bp_b2_last", out_last, 1);
    @(negedge clock);
    checkOutput("bp_end_valid", out_valid, 0);
    checkOutput("bp_end_ready", in_ready, 1);

    // Asynchronous reset in the middle of a burst
    out_ready = 1'b1;
    applyStimulus(5'd8, 6'd10);
    repeat (3) @(negedge clock);
    checkOutput("mid_code", out_code, 11);
    clear = 1'b0;
    #1;
    checkOutput("mid_rst_data", Data, 0);
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    @(negedge clock);
    clear = 1'b1;
    #1;
    checkOutput("mid_rel_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clock);
      checkOutput("mid_no_beat", out_valid, 0);
    end

    // Randomized bursts with random back-pressure
    for (int r = 0; r < 40; r++) begin
      rc = 5'($urandom_range(31));
      rn = 6'($urandom_range(63));
      drive_burst(rc, rn, 60, beats, first_data, last_code);
      checkOutput("rnd_beats", beats, model_beats(rn));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_burst_decoder.md
Name: onehot_burst_decoder

Overview:
- Sequential 5-to-32 decoder: the inverse of the 32-to-5 priority encoder on the register-select path.
- Accepts a start register code and a beat count over a valid/ready handshake.
- Emits a registered one-hot 32-bit enable vector per beat, stepping through consecutive register codes with wrap-around.
- Drives register-file load/out enables for single and multi-register (burst) transfers on the CPU bus.

Parameters:
- N_REGS, 32, number of one-hot outputs; fixed at 32, code width 5.
- CNT_W, 6, width of in_count; encodes burst lengths up to 32.

Ports:
- clock  in  1  system clock, rising-edge
- clear  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_code  in  5  start register code, 0..31
- in_count  in  6  burst length in beats
- out_valid  out  1  Data/out_code hold a valid beat
- out_ready  in  1  consumer accepts the current beat
- Data  out  32  one-hot enable: bit out_code set, all others 0
- out_code  out  5  register code of the current beat
- out_last  out  1  current beat is the final beat of the burst
- busy  out  1  burst in progress (state RUN)
- err  out  1  only present with ONEHOT_DEC_CHK_EN; see Optional Feature

Behaviour:
- Clock and reset:
  - Single clock domain.
  - clear=0 asynchronously forces: state=IDLE, Data=0, out_code=0, out_valid=0, out_last=0, busy=0, err=0, remaining=0.
  - Reset mid-burst abandons the burst with no further beats.
  - in_ready=1 is visible as soon as clear is released.
- States: IDLE, RUN.
  - in_ready = (state==IDLE), decoded directly from state with no dependence on in_valid.
  - busy = (state==RUN).
- IDLE:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - On accept: out_code<=in_code; Data<=1<<in_code; remaining<=effective count (see count rules); out_last<=(effective count==1); out_valid<=1; state<=RUN.
  - Latency: the first beat is visible in the cycle after the accepting edge.
- RUN:
  - Stall: when out_valid=1 and out_ready=0, Data, out_code, out_last and remaining hold unchanged.
  - Beat handshake: out_valid & out_ready at an edge.
    - If out_last=1: out_valid<=0, Data<=0, out_last<=0, state<=IDLE.
    - Otherwise: out_code<=out_code+1 mod 32 (31 wraps to 0), Data rotates left by 1 (bit31 wraps to bit0), remaining<=remaining-1, out_last<=(remaining==2).
  - Throughput is one beat per cycle while out_ready is held high.
  - in_valid is ignored in RUN.
  - A new request can be accepted in the cycle after the last beat handshake, giving a one-cycle bubble between bursts.
- Invariants:
  - Data is all-zero whenever out_valid=0.
  - Data has exactly one bit set whenever out_valid=1.
- Count rules without macro:
  - in_count==0 is treated as 32.
  - in_count>32 saturates to 32.
  - A 32-beat burst visits every register exactly once.

Optional Feature:
- Macro: ONEHOT_DEC_CHK_EN.
- Defined:
  - Adds output port err.
  - in_count==0 or in_count>32 is still accepted (in_ready=1 handshake completes), but no beats are emitted and state stays IDLE.
  - err pulses high for exactly one cycle following the accepting edge.
  - Valid counts behave identically to the build without the macro.
- Not defined: no err port; count rules as above.

Test Plan:
- Reset state: clear=0 for 2 cycles, then release -> Data=0, out_valid=0, busy=0, in_ready=1.
- Single beat: in_code=5, in_count=1, out_ready=1 -> next cycle Data=32'h00000020, out_code=5, out_last=1; one cycle later out_valid=0, in_ready=1.
- Wrap-around burst: in_code=30, in_count=4, out_ready=1 -> successive Data = 32'h40000000, 32'h80000000, 32'h00000001, 32'h00000002; out_last high only on the 4th beat.
- Back-pressure: in_code=0, in_count=3; out_ready=0 for 3 cycles after the first beat -> Data holds at 32'h00000001 and out_code holds at 0; after out_ready=1, beats 1 and 2 follow with no skipped or duplicated beat.
- Reset mid-burst: in_code=8, in_count=10; assert clear=0 after the 3rd beat -> Data=0 and out_valid=0 immediately (asynchronous); after release, in_ready=1 and no residual beats.
- Count edge cases: in_count=0 without macro -> 32 beats, codes 0..31, starting from the requested in_code and wrapping. With ONEHOT_DEC_CHK_EN and in_count=40 -> err=1 for one cycle, out_valid stays 0, in_ready=1.
